// File: rtl/bet_entry_buffer_pkg.sv
// Shared roulette game definitions: keypad codes, bet buffer states and default sizing.
package bet_entry_buffer_pkg;

    localparam int DEF_MAX_PICKS = 4;
    localparam int DEF_NUM_SLOTS = 8;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SCORED = 2'd2
    } bet_state_e;

endpackage

// File: rtl/bet_hit_counter.sv
// Combinational count of stored picks whose 1-based slot equals the 0-based wheel stop.
module bet_hit_counter #(
    parameter int MAX_PICKS = 4,
    parameter int NUM_SLOTS = 8,
    parameter int CNT_W     = $clog2(MAX_PICKS + 1),
    parameter int POS_W     = $clog2(NUM_SLOTS)
) (
    input  logic [MAX_PICKS*4-1:0] picks,
    input  logic [CNT_W-1:0]       pick_count,
    input  logic [POS_W-1:0]       result_pos,
    output logic [CNT_W-1:0]       hit_count
);

    logic [3:0] target_s;

    assign target_s = 4'(result_pos) + 4'd1;

    // Population count over the occupied entries only.
    always_comb begin
        hit_count = '0;
        for (int k = 0; k < MAX_PICKS; k++) begin
            hit_count = hit_count +
                (((CNT_W'(k) < pick_count) && (picks[4*k +: 4] == target_s)) ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/bet_entry_buffer.sv
// Pick-entry and result-scoring buffer for the roulette game.
// Optional BET_DEDUP_EN: reject a digit already stored in the buffer.
module bet_entry_buffer
    import bet_entry_buffer_pkg::*;
#(
    parameter int MAX_PICKS = DEF_MAX_PICKS,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int CNT_W     = $clog2(MAX_PICKS + 1),
    parameter int POS_W     = $clog2(NUM_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [3:0]             key_value,
    input  logic                   entry_en,
    input  logic [CNT_W-1:0]       bet_count,
    input  logic                   clear,
    input  logic                   lock,
    input  logic                   result_valid,
    input  logic [POS_W-1:0]       result_pos,
    output logic [CNT_W-1:0]       pick_count,
    output logic [MAX_PICKS*4-1:0] picks_flat,
    output logic                   entry_full,
    output logic                   locked,
    output logic                   hit_valid,
    output logic [CNT_W-1:0]       hit_count,
    output logic                   win_flag,
    output logic                   err_pulse
);

    localparam logic [3:0]       MAX_DIGIT = 4'(NUM_SLOTS);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PICKS);

    bet_state_e             state_r, state_nxt_s;
    logic [MAX_PICKS*4-1:0] picks_r, picks_nxt_s;
    logic [CNT_W-1:0]       pick_count_r, pick_count_nxt_s;
    logic [CNT_W-1:0]       hit_count_r, hit_count_nxt_s, hit_s;
    logic                   entry_full_r, locked_r, hit_valid_r, win_flag_r, err_pulse_r;
    logic                   hit_valid_nxt_s, win_flag_nxt_s, err_nxt_s;
    logic                   full_now_s, room_s, dup_s, is_digit_s, in_range_s, key_act_s;

    bet_hit_counter #(
        .MAX_PICKS (MAX_PICKS),
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W),
        .POS_W     (POS_W)
    ) u_hit_counter (
        .picks      (picks_r),
        .pick_count (pick_count_r),
        .result_pos (result_pos),
        .hit_count  (hit_s)
    );

    assign full_now_s = (pick_count_r == bet_count) && (bet_count != '0);
    assign room_s     = (pick_count_r < bet_count) && (pick_count_r < MAX_CNT);
    assign is_digit_s = (key_value >= 4'd1) && (key_value <= 4'd9);
    assign in_range_s = (key_value >= 4'd1) && (key_value <= MAX_DIGIT);
    assign key_act_s  = key_valid && entry_en && (state_r == ST_ENTRY);

    // Duplicate detection against the occupied entries.
    always_comb begin
        dup_s = 1'b0;
`ifdef BET_DEDUP_EN
        for (int k = 0; k < MAX_PICKS; k++) begin
            dup_s = dup_s | ((CNT_W'(k) < pick_count_r) && (picks_r[4*k +: 4] == key_value));
        end
`endif
    end

    // Next-state decode in priority order clear > lock > result_valid > key.
    always_comb begin
        state_nxt_s      = state_r;
        picks_nxt_s      = picks_r;
        pick_count_nxt_s = pick_count_r;
        hit_count_nxt_s  = hit_count_r;
        win_flag_nxt_s   = win_flag_r;
        hit_valid_nxt_s  = 1'b0;
        err_nxt_s        = 1'b0;
        if (clear) begin
            state_nxt_s      = ST_ENTRY;
            picks_nxt_s      = '0;
            pick_count_nxt_s = '0;
            hit_count_nxt_s  = '0;
            win_flag_nxt_s   = 1'b0;
        end else if (lock && (state_r == ST_ENTRY)) begin
            if (full_now_s) begin
                state_nxt_s = ST_LOCKED;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else if (result_valid && (state_r == ST_LOCKED)) begin
            hit_count_nxt_s = hit_s;
            win_flag_nxt_s  = (hit_s != '0);
            hit_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_SCORED;
        end else if (key_act_s) begin
            case (key_value)
                KEY_STAR: begin
                    if (pick_count_r != '0) begin
                        for (int k = 0; k < MAX_PICKS; k++) begin
                            picks_nxt_s[4*k +: 4] = (CNT_W'(k + 1) == pick_count_r) ? 4'd0 : picks_r[4*k +: 4];
                        end
                        pick_count_nxt_s = pick_count_r - CNT_W'(1);
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                KEY_HASH: begin
                    picks_nxt_s      = '0;
                    pick_count_nxt_s = '0;
                end
                default: begin
                    if (in_range_s && room_s && !dup_s) begin
                        for (int k = 0; k < MAX_PICKS; k++) begin
                            picks_nxt_s[4*k +: 4] = (CNT_W'(k) == pick_count_r) ? key_value : picks_r[4*k +: 4];
                        end
                        pick_count_nxt_s = pick_count_r + CNT_W'(1);
                    end else begin
                        err_nxt_s = is_digit_s;
                    end
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_ENTRY;
            picks_r      <= '0;
            pick_count_r <= '0;
            hit_count_r  <= '0;
            entry_full_r <= 1'b0;
            locked_r     <= 1'b0;
            hit_valid_r  <= 1'b0;
            win_flag_r   <= 1'b0;
            err_pulse_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            picks_r      <= picks_nxt_s;
            pick_count_r <= pick_count_nxt_s;
            hit_count_r  <= hit_count_nxt_s;
            entry_full_r <= (pick_count_nxt_s == bet_count) && (bet_count != '0);
            locked_r     <= (state_nxt_s != ST_ENTRY);
            hit_valid_r  <= hit_valid_nxt_s;
            win_flag_r   <= win_flag_nxt_s;
            err_pulse_r  <= err_nxt_s;
        end
    end

    assign pick_count = pick_count_r;
    assign picks_flat = picks_r;
    assign entry_full = entry_full_r;
    assign locked     = locked_r;
    assign hit_valid  = hit_valid_r;
    assign hit_count  = hit_count_r;
    assign win_flag   = win_flag_r;
    assign err_pulse  = err_pulse_r;

endmodule

// File: tb/tb_bet_entry_buffer.sv
// Directed self-checking bench: default 4x8 instance plus an 8-pick, 9-slot instance.
module tb_bet_entry_buffer;

    logic        clk = 1'b0;
    logic        rst, key_valid, entry_en, clear, lock, result_valid;
    logic [3:0]  key_value;
    logic [2:0]  bet_count, result_pos;
    logic [3:0]  bet_count_b, result_pos_b;

    logic [2:0]  pick_count, hit_count;
    logic [15:0] picks_flat;
    logic        entry_full, locked, hit_valid, win_flag, err_pulse;
    logic [3:0]  pick_count_b, hit_count_b;
    logic [31:0] picks_flat_b;
    logic        entry_full_b, locked_b, hit_valid_b, win_flag_b, err_pulse_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bet_entry_buffer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_value(key_value), .entry_en(entry_en),
        .bet_count(bet_count), .clear(clear), .lock(lock), .result_valid(result_valid),
        .result_pos(result_pos), .pick_count(pick_count), .picks_flat(picks_flat),
        .entry_full(entry_full), .locked(locked), .hit_valid(hit_valid), .hit_count(hit_count),
        .win_flag(win_flag), .err_pulse(err_pulse)
    );

    bet_entry_buffer #(.MAX_PICKS(8), .NUM_SLOTS(9)) dut_b (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_value(key_value), .entry_en(entry_en),
        .bet_count(bet_count_b), .clear(clear), .lock(lock), .result_valid(result_valid),
        .result_pos(result_pos_b), .pick_count(pick_count_b), .picks_flat(picks_flat_b),
        .entry_full(entry_full_b), .locked(locked_b), .hit_valid(hit_valid_b), .hit_count(hit_count_b),
        .win_flag(win_flag_b), .err_pulse(err_pulse_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        key_value = v;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_lock();
        lock = 1'b1;
        tick();
        lock = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_result(input logic [2:0] pa, input logic [3:0] pb);
        result_pos   = pa;
        result_pos_b = pb;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_value = 4'd0; entry_en = 1'b0; clear = 1'b0;
        lock = 1'b0; result_valid = 1'b0; bet_count = 3'd0; result_pos = 3'd0;
        bet_count_b = 4'd0; result_pos_b = 4'd0;
        #12;
        check("rst_pick_count", 32'(pick_count), 32'd0);
        check("rst_picks", 32'(picks_flat), 32'd0);
        check("rst_flags", {entry_full, locked, hit_valid, win_flag, err_pulse}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic round: 2,5,7 then stop at slot 4 (digit 5)
        entry_en = 1'b1; bet_count = 3'd3;
        press(4'd2); press(4'd5); press(4'd7);
        check("s1_pick_count", 32'(pick_count), 32'd3);
        check("s1_picks", 32'(picks_flat), 32'h0752);
        check("s1_full", 32'(entry_full), 32'd1);
        do_lock();
        check("s1_locked", 32'(locked), 32'd1);
        check("s1_lock_err", 32'(err_pulse), 32'd0);
        press(4'd3);
        check("s1_key_in_locked", 32'(pick_count), 32'd3);
        do_result(3'd4, 4'd0);
        check("s1_hit_valid", 32'(hit_valid), 32'd1);
        check("s1_hit_count", 32'(hit_count), 32'd1);
        check("s1_win", 32'(win_flag), 32'd1);
        do_result(3'd1, 4'd0);
        check("s1_hv_pulse", 32'(hit_valid), 32'd0);
        check("s1_hold", 32'(hit_count), 32'd1);
        do_clear();
        check("s1_clr", {29'd0, locked, win_flag, hit_valid}, 32'd0);
        check("s1_clr_cnt", {26'd0, pick_count, hit_count}, 32'd0);

        // Duplicate handling
        bet_count = 3'd2;
        press(4'd3); press(4'd3);
`ifdef BET_DEDUP_EN
        check("s2_dup_err", 32'(err_pulse), 32'd1);
        check("s2_dup_cnt", 32'(pick_count), 32'd1);
`else
        check("s2_dup_err", 32'(err_pulse), 32'd0);
        check("s2_dup_cnt", 32'(pick_count), 32'd2);
        do_lock();
        do_result(3'd2, 4'd0);
        check("s2_dup_hits", 32'(hit_count), 32'd2);
`endif
        do_clear();

        // Backspace, rejected lock, clear-all
        bet_count = 3'd4;
        press(4'd1); press(4'd2); press(4'd10);
        check("s3_bs_err", 32'(err_pulse), 32'd0);
        press(4'd6);
        check("s3_picks", 32'(picks_flat), 32'h0061);
        check("s3_cnt", 32'(pick_count), 32'd2);
        do_lock();
        check("s3_lock_err", 32'(err_pulse), 32'd1);
        check("s3_not_locked", 32'(locked), 32'd0);
        tick();
        check("s3_err_width", 32'(err_pulse), 32'd0);
        press(4'd11);
        check("s3_hash", {16'd0, picks_flat} | 32'(pick_count), 32'd0);
        press(4'd10);
        check("s3_bs_empty_err", 32'(err_pulse), 32'd1);

        // Out-of-range, non-digit, disabled entry, full buffer
        press(4'd9);
        check("s4_nine_err", 32'(err_pulse), 32'd1);
        check("s4_nine_cnt", 32'(pick_count), 32'd0);
        press(4'd0);
        check("s4_zero_err", 32'(err_pulse), 32'd0);
        entry_en = 1'b0;
        press(4'd4);
        check("s4_dis_cnt", 32'(pick_count), 32'd0);
        entry_en = 1'b1; bet_count = 3'd1;
        press(4'd4); press(4'd5);
        check("s4_full_err", 32'(err_pulse), 32'd1);
        check("s4_full_cnt", 32'(picks_flat), 32'h0004);

        // Clear beats result_valid in the same cycle
        do_lock();
        check("s5_locked", 32'(locked), 32'd1);
        clear = 1'b1; result_pos = 3'd3; result_valid = 1'b1;
        tick();
        clear = 1'b0; result_valid = 1'b0;
        check("s5_state", {29'd0, locked, hit_valid, win_flag}, 32'd0);
        check("s5_hit_count", 32'(hit_count), 32'd0);

        // Asynchronous reset from SCORED
        press(4'd4); do_lock(); do_result(3'd3, 4'd0);
        check("s6_win", 32'(win_flag), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("s6_async_rst", {pick_count, hit_count, locked, win_flag, entry_full, picks_flat}, 32'd0);
        rst = 1'b0;
        tick();

        // 8-pick, 9-slot instance
        bet_count = 3'd0; bet_count_b = 4'd8;
        press(4'd9);
        for (int d = 1; d <= 7; d++) press(4'(d));
        check("b_cnt", 32'(pick_count_b), 32'd8);
        check("b_picks", picks_flat_b, 32'h76543219);
        do_lock();
        do_result(3'd0, 4'd8);
        check("b_hit9", 32'(hit_count_b), 32'd1);
        do_clear();
        for (int d = 1; d <= 8; d++) press(4'(d));
        check("b_picks2", picks_flat_b, 32'h87654321);
        do_lock();
        do_result(3'd0, 4'd8);
        check("b_hit_none", {30'd0, hit_valid_b, win_flag_b} | 32'(hit_count_b), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bet_entry_buffer.md
# bet_entry_buffer

Parametrised pick-entry and result-scoring buffer for the roulette game. It collects up to MAX_PICKS slot numbers from the keypad decoder while the game FSM is in its number-input phase, with backspace, clear-all and duplicate rejection. It locks the picks when the spin starts, then scores them against the wheel's stop position. It sits between the keypad decoder, the game FSM, the roulette LED driver and the money/LCD blocks, and replaces the fixed 4-pick, 8-slot entry registers.

## Interface
- MAX_PICKS, 4: maximum numbers per bet (1..15).
- NUM_SLOTS, 8: wheel slots; valid digits 1..NUM_SLOTS (2..9).
- CNT_W, $clog2(MAX_PICKS+1): width of pick and hit counts (derived).
- POS_W, $clog2(NUM_SLOTS): width of result_pos (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- key_valid  in  1  one-cycle keypad strobe.
- key_value  in  4  key code: 1..9 digit, 10 '*' backspace, 11 '#' clear-all.
- entry_en  in  1  high while the FSM is in the number-input state.
- bet_count  in  CNT_W  picks required this round, sampled every cycle.
- clear  in  1  round reset; empties the buffer and returns to ENTRY.
- lock  in  1  spin-start strobe.
- result_valid  in  1  wheel-stopped strobe.
- result_pos  in  POS_W  0-based stop slot, already board-mapped.
- pick_count  out  CNT_W  picks stored.
- picks_flat  out  MAX_PICKS*4  pick k in bits [4k+3:4k]; empty entries are 0.
- entry_full  out  1  pick_count == bet_count and bet_count != 0.
- locked  out  1  high in LOCKED or SCORED.
- hit_valid  out  1  one-cycle pulse when hit_count is updated.
- hit_count  out  CNT_W  matching picks.
- win_flag  out  1  hit_count != 0.
- err_pulse  out  1  one-cycle pulse on a rejected key or lock.

## Operation
- States: ENTRY (reset state), LOCKED, SCORED.
- ENTRY, entry_en=1, key_valid=1:
  - Digit d in 1..NUM_SLOTS with pick_count < bet_count and d not a duplicate: stored at index pick_count, and pick_count increments.
  - Digit while full, digit out of range, or duplicate: dropped, err_pulse.
  - '*': if pick_count > 0, clears the last entry and decrements pick_count; otherwise err_pulse.
  - '#': zeroes all entries and sets pick_count to 0.
  - Any other code: ignored, no error.
- Keys are ignored when entry_en=0 or when the state is not ENTRY.
- ENTRY + lock:
  - If entry_full, go to LOCKED. Picks are frozen.
  - Otherwise err_pulse and stay in ENTRY.
- LOCKED + result_valid: hit_count = number of k < pick_count with picks[k]-1 == result_pos. Set win_flag, pulse hit_valid, go to SCORED.
- SCORED: outputs held until clear. Further result_valid and lock strobes are ignored.
- clear in any state: ENTRY, picks zeroed, pick_count, hit_count and win_flag set to 0.
- Lowering bet_count below pick_count does not drop stored picks. Lock is rejected until the user backspaces.

## Timing
- Reset values: all outputs 0, state ENTRY, picks zeroed.
- All outputs are registered. Key effects are visible at N+1 for a strobe at cycle N.
- locked rises one cycle after an accepted lock.
- hit_valid, hit_count and win_flag update one cycle after result_valid, all in the same cycle.
- err_pulse is exactly one cycle wide, one cycle after the offending strobe.
- Priority: rst > clear > lock > result_valid > key. A key in the same cycle as an accepted lock is dropped.
- Asserting rst mid-round aborts everything. The next round starts with an empty buffer.

## Configuration
- BET_DEDUP_EN:
  - Defined: a digit equal to any stored pick is rejected with err_pulse.
  - Undefined: duplicates are accepted and scored per copy, so a duplicate hit counts twice.

## Structure
- Shared game package holds:
  - Key codes: KEY_STAR=10, KEY_HASH=11.
  - State encoding for ENTRY, LOCKED, SCORED.
  - Default MAX_PICKS and NUM_SLOTS.
- One sub-module, bet_hit_counter: combinational population count of matches over MAX_PICKS entries. It is registered in the parent.

## Test plan
- Defaults, bet_count=3, keys 2,5,7, then lock, then result_pos=4 -> pick_count=3, entry_full=1, locked=1, hit_count=1, win_flag=1.
- bet_count=2, keys 3,3 with BET_DEDUP_EN -> second 3 gives err_pulse, pick_count=1. Without the macro: pick_count=2, and result_pos=2 gives hit_count=2.
- bet_count=4, keys 1,2, '*', 6, then lock -> picks 1,6, lock rejected with err_pulse, locked=0. Then '#' -> pick_count=0, picks_flat=0.
- Keys 9 and 0 at NUM_SLOTS=8 -> dropped; 9 gives err_pulse, 0 gives no error. A key with entry_en=0 -> no change.
- LOCKED, then clear and result_valid in the same cycle -> ENTRY, hit_valid=0, hit_count=0.
- rst asserted in SCORED -> all outputs 0 asynchronously. MAX_PICKS=8, NUM_SLOTS=9: eight unique picks with result_pos=8 -> hit_count=1 only if 9 was picked.
